// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the divide-by-zero quotient pattern.
package alu_div_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 32;
    localparam int DIV_MAX_WIDTH     = 64;

    // All-ones quotient for a zero divisor; users slice it to their WIDTH.
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_DBZ_QUOTIENT_ALL = '1;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract the
// divisor magnitude, keep the difference only when it is non-negative.
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One spare bit above A makes the borrow visible as the trial's MSB.
    assign shifted = {a, q[WIDTH-1]};
    assign trial   = shifted - {2'b00, d};

    always_comb begin
        a_next = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
        q_next = {q[WIDTH-2:0], ~trial[WIDTH+1]};
    end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Handshake: start is sampled only in IDLE; busy marks the op in flight;
// done pulses one cycle when quotient/remainder/result are valid.
module alu_div_seq
    import alu_div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         dbg_state
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        dividend_neg = signed_mode & dividend[WIDTH-1];
        divisor_neg  = signed_mode & divisor[WIDTH-1];
        dividend_abs = dividend_neg ? -dividend : dividend;
        divisor_abs  = divisor_neg  ? -divisor  : divisor;
    end

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .a      (acc),
        .q      (q),
        .d      (dvs_abs),
        .a_next (acc_next),
        .q_next (q_next)
    );

    // Outputs are registered from the current state, so each lands one edge
    // after its state is entered; a zero divisor passes through FIX to take
    // the same path to DONE without any RUN steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            dvs_abs     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        acc         <= '0;
                        q           <= dividend_abs;
                        dvs_abs     <= divisor_abs;
                        dvd_raw     <= dividend;
                        neg_q       <= dividend_neg ^ divisor_neg;
                        neg_r       <= dividend_neg;
                        dbz         <= (divisor == '0);
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        state       <= (divisor == '0) ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    busy <= 1'b1;
                    acc  <= acc_next;
                    q    <= q_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy <= 1'b1;
                    if (dbz) begin
                        quotient  <= DIV_DBZ_QUOTIENT_ALL[WIDTH-1:0];
                        remainder <= dvd_raw;
                    end else begin
                        quotient  <= neg_q ? -q : q;
                        remainder <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dbz;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign result    = {remainder, quotient};
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: vector table, randomized ops against
// an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_alu_div_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] dd32 = '0, dv32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] q32, r32;
    logic [63:0] res32;
    logic [1:0]  st32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  q8, r8;
    logic [15:0] res8;
    logic [1:0]  st8;

    alu_div_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
        .dividend(dd32), .divisor(dv32), .busy(busy32), .done(done32),
        .div_by_zero(dz32), .quotient(q32), .remainder(r32), .result(res32),
        .dbg_state(st32)
    );

    alu_div_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8),
        .div_by_zero(dz8), .quotient(q8), .remainder(r8), .result(res8),
        .dbg_state(st8)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          w8;
        bit          sm;
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] eq;
        logic [31:0] er;
        bit          edz;
        int          elat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Truncating division from plain integer arithmetic on w-bit values.
    function automatic void ref_div(input int w, input bit sm, input logic [31:0] dd,
                                    input logic [31:0] dv, output logic [31:0] q,
                                    output logic [31:0] r, output bit dz);
        longint mask, a, b, qq, rr;
        mask = (longint'(1) << w) - 1;
        a = longint'(dd) & mask;
        b = longint'(dv) & mask;
        if (b == 0) begin
            q  = 32'(mask);
            r  = 32'(a);
            dz = 1'b1;
            return;
        end
        if (sm && a[w-1]) a = a - (longint'(1) << w);
        if (sm && b[w-1]) b = b - (longint'(1) << w);
        qq = a / b;
        rr = a % b;
        q  = 32'(qq & mask);
        r  = 32'(rr & mask);
        dz = 1'b0;
    endfunction

    task automatic wait_done32(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (done32) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic run_op(input bit w8, input bit sm, input logic [31:0] dd, input logic [31:0] dv,
                          output logic [31:0] q, output logic [31:0] r, output logic dz,
                          output logic [63:0] res, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; sm8 = sm; dd8 = dd[7:0]; dv8 = dv[7:0];
        end else begin
            start32 = 1'b1; sm32 = sm; dd32 = dd; dv32 = dv;
        end
        @(posedge clk); @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        // Scramble inputs after acceptance; the running op must not see them.
        dd32 = $urandom; dv32 = $urandom; dd8 = 8'($urandom); dv8 = 8'($urandom);
        sm32 = 1'($urandom_range(0, 1)); sm8 = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (w8 ? busy8 : busy32) bcnt++;
            if (w8 ? done8 : done32) begin
                lat = k;
                break;
            end
        end
        if (w8) begin
            q = {24'b0, q8}; r = {24'b0, r8}; dz = dz8; res = {48'b0, res8};
        end else begin
            q = q32; r = r32; dz = dz32; res = res32;
        end
    endtask

    task automatic check_op(input string tag, input bit w8, input bit sm,
                            input logic [31:0] dd, input logic [31:0] dv,
                            input logic [31:0] eq, input logic [31:0] er,
                            input bit edz, input int elat);
        logic [31:0] q, r;
        logic        dz;
        logic [63:0] res, eres;
        int          lat, bcnt;
        run_op(w8, sm, dd, dv, q, r, dz, res, lat, bcnt);
        eres = w8 ? {48'b0, er[7:0], eq[7:0]} : {er, eq};
        check($sformatf("%s_quotient", tag), q, eq);
        check($sformatf("%s_remainder", tag), r, er);
        check($sformatf("%s_dbz", tag), dz, edz);
        check($sformatf("%s_result", tag), res, eres);
        check($sformatf("%s_latency", tag), lat, elat);
        check($sformatf("%s_busy_cycles", tag), bcnt, elat - 1);
    endtask

    initial begin
        logic [31:0] rq, rr, dd, dv;
        bit          rdz, w8, sm;
        int          lat, sel;

        vecs[0]  = '{0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 34};
        vecs[1]  = '{0, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 34};
        vecs[2]  = '{0, 1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 34};
        vecs[3]  = '{0, 0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          0, 34};
        vecs[4]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 34};
        vecs[5]  = '{0, 0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1, 2};
        vecs[6]  = '{0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          0, 34};
        vecs[7]  = '{1, 0, 32'd200,        32'd3,          32'd66,         32'd2,          0, 10};
        vecs[8]  = '{1, 1, 32'h80,         32'd3,          32'hD6,         32'hFE,         0, 10};
        vecs[9]  = '{0, 1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1, 2};
        vecs[10] = '{0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          0, 34};
        vecs[11] = '{1, 0, 32'd5,          32'd0,          32'hFF,         32'd5,          1, 2};

        // Clock/reset: reset asserted away from any edge, released on a negedge.
        #3 rst_n = 1'b0;
        #1;
        check("reset_busy", busy32, 1'b0);
        check("reset_done", done32, 1'b0);
        check("reset_dbz", dz32, 1'b0);
        check("reset_result", res32, 64'd0);
        check("reset_state", st32, 2'd0);
        check("reset_result8", res8, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].w8, vecs[i].sm, vecs[i].dd, vecs[i].dv,
                     vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat);

        for (int i = 0; i < 40; i++) begin
            w8  = 1'($urandom_range(0, 1));
            sm  = 1'($urandom_range(0, 1));
            dd  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      dv = 32'd0;
            else if (sel < 4)  dv = 32'($urandom_range(1, 15));
            else if (sel < 6)  dv = -32'($urandom_range(1, 15));
            else               dv = $urandom;
            if (w8 && dv[7:0] == 8'd0 && sel != 0) dv = 32'd1;
            ref_div(w8 ? 8 : 32, sm, dd, dv, rq, rr, rdz);
            check_op($sformatf("rnd%0d", i), w8, sm, dd, dv, rq, rr, rdz,
                     rdz ? 2 : (w8 ? 10 : 34));
        end

        // A start with new operands at edge 10 of a running op is ignored.
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b0; dd32 = 32'd1000; dv32 = 32'd10;
        @(posedge clk); @(negedge clk);
        start32 = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        start32 = 1'b1; dd32 = 32'd5; dv32 = 32'd1;
        @(posedge clk); @(negedge clk);
        start32 = 1'b0;
        wait_done32(lat);
        check("ignore_latency", lat, 24);
        check("ignore_quotient", q32, 32'd100);
        check("ignore_remainder", r32, 32'd0);

        // Held start re-triggers with one idle cycle after the done pulse.
        @(negedge clk);
        start32 = 1'b1; sm32 = 1'b0; dd32 = 32'd100; dv32 = 32'd7;
        wait_done32(lat);
        check("held_first_quotient", q32, 32'd14);
        dd32 = 32'd50; dv32 = 32'd6;
        @(posedge clk); @(negedge clk);
        check("held_gap_busy", busy32, 1'b0);
        check("held_gap_done", done32, 1'b0);
        @(posedge clk); @(negedge clk);
        check("held_restart_busy", busy32, 1'b1);
        start32 = 1'b0;
        wait_done32(lat);
        check("held_second_latency", lat, 33);
        check("held_second_quotient", q32, 32'd8);
        check("held_second_remainder", r32, 32'd2);

        // Asynchronous reset in the middle of an op clears everything at once.
        @(negedge clk);
        start32 = 1'b1; dd32 = 32'd1000; dv32 = 32'd3;
        @(posedge clk); @(negedge clk);
        start32 = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy32, 1'b0);
        check("async_rst_result", res32, 64'd0);
        check("async_rst_state", st32, 2'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", st32, 2'd0);
        check("post_rst_done", done32, 1'b0);
        check_op("post_rst", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
